// File: rtl/lsu_mc.sv
// Multi-cycle load/store unit: takes one execute-stage memory op, issues a single
// lane-steered request on the data-memory port, and returns extended load data or a store ack.
module lsu_mc #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned AW   = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic            wen_i,
   input  logic            ren_i,
   input  logic            is_load_signed_i,
   input  logic [1:0]      size_i,
   input  logic [AW-1:0]   addr_i,
   input  logic [XLEN-1:0] wdata_i,
   input  logic [4:0]      rd_i,
   output logic            mem_req_valid_o,
   input  logic            mem_req_ready_i,
   output logic            mem_req_we_o,
   output logic [AW-1:0]   mem_req_addr_o,
   output logic [XLEN-1:0] mem_req_wdata_o,
   output logic [3:0]      mem_req_wstrb_o,
   input  logic            mem_resp_valid_i,
   input  logic [XLEN-1:0] mem_resp_rdata_i,
   input  logic            mem_resp_err_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [XLEN-1:0] out_rdata_o,
   output logic [4:0]      out_rd_o,
   output logic            out_we_o,
   output logic            out_err_o
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t state_q, state_d;

   logic            accept;
   logic            misaligned;
   logic            illegal;
   logic            no_access;
   logic [3:0]      strb;
   logic [XLEN-1:0] lanes;
   logic [XLEN-1:0] shifted;
   logic [XLEN-1:0] load_ext;
   logic [1:0]      size_q;
   logic [1:0]      off_q;
   logic            signed_q;

   assign accept     = (state_q == IDLE) && in_valid_i;
   assign misaligned = ((size_i == 2'd1) && addr_i[0]) ||
                       ((size_i == 2'd2) && (addr_i[1:0] != 2'b00));
   assign illegal    = misaligned || (size_i == 2'd3) || (wen_i && ren_i);
   assign no_access  = !wen_i && !ren_i;

   assign in_ready_o      = (state_q == IDLE);
   assign mem_req_valid_o = (state_q == REQ);
   assign out_valid_o     = (state_q == DONE);

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (in_valid_i) state_d = (illegal || no_access) ? DONE : REQ;
         REQ:  if (mem_req_ready_i) state_d = WAIT;
         WAIT: if (mem_resp_valid_i) state_d = DONE;
         DONE: if (out_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      strb  = '0;
      lanes = '0;
      case (size_i)
         2'd0: begin
            strb  = 4'b0001 << addr_i[1:0];
            lanes = {4{wdata_i[7:0]}};
         end
         2'd1: begin
            strb  = 4'b0011 << addr_i[1:0];
            lanes = {2{wdata_i[15:0]}};
         end
         default: begin
            strb  = 4'b1111;
            lanes = wdata_i;
         end
      endcase
   end

   always_comb begin
      shifted  = mem_resp_rdata_i >> {off_q, 3'b000};
      load_ext = shifted;
      case (size_q)
         2'd0:    load_ext = {{(XLEN-8){signed_q & shifted[7]}}, shifted[7:0]};
         2'd1:    load_ext = {{(XLEN-16){signed_q & shifted[15]}}, shifted[15:0]};
         default: load_ext = shifted;
      endcase
   end

   // Result fields are preset at accept so the error / no-access paths skip straight to DONE.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         size_q          <= '0;
         off_q           <= '0;
         signed_q        <= 1'b0;
         mem_req_we_o    <= 1'b0;
         mem_req_addr_o  <= '0;
         mem_req_wdata_o <= '0;
         mem_req_wstrb_o <= '0;
         out_rdata_o     <= '0;
         out_rd_o        <= '0;
         out_we_o        <= 1'b0;
         out_err_o       <= 1'b0;
      end else begin
         if (accept) begin
            size_q      <= size_i;
            off_q       <= addr_i[1:0];
            signed_q    <= is_load_signed_i;
            out_rd_o    <= rd_i;
            out_err_o   <= illegal;
            out_we_o    <= 1'b0;
            out_rdata_o <= '0;
            if (!illegal && !no_access) begin
               mem_req_we_o    <= wen_i;
               mem_req_addr_o  <= {addr_i[AW-1:2], 2'b00};
               mem_req_wdata_o <= wen_i ? lanes : '0;
               mem_req_wstrb_o <= wen_i ? strb : 4'b0000;
            end
         end
         if ((state_q == WAIT) && mem_resp_valid_i) begin
            out_err_o   <= mem_resp_err_i;
            out_we_o    <= !mem_resp_err_i && !mem_req_we_o;
            out_rdata_o <= (!mem_resp_err_i && !mem_req_we_o) ? load_ext : '0;
         end
      end
   end

endmodule

// File: tb/tb_lsu_mc.sv
// Bench for lsu_mc: directed scenarios plus randomized operations checked
// against an arithmetic reference of the lane, strobe and extension rules.
module tb_lsu_mc;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, wen, ren, sgn;
   logic [1:0]  size;
   logic [31:0] addr, wdata;
   logic [4:0]  rd;
   logic        req_valid, req_ready, req_we;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_wstrb;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic        out_valid, out_ready, out_we, out_err;
   logic [31:0] out_rdata;
   logic [4:0]  out_rd;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   lsu_mc #(.XLEN(32), .AW(32)) dut (
      .clk_i(clk), .rst_i(rst),
      .in_valid_i(in_valid), .in_ready_o(in_ready),
      .wen_i(wen), .ren_i(ren), .is_load_signed_i(sgn),
      .size_i(size), .addr_i(addr), .wdata_i(wdata), .rd_i(rd),
      .mem_req_valid_o(req_valid), .mem_req_ready_i(req_ready),
      .mem_req_we_o(req_we), .mem_req_addr_o(req_addr),
      .mem_req_wdata_o(req_wdata), .mem_req_wstrb_o(req_wstrb),
      .mem_resp_valid_i(resp_valid), .mem_resp_rdata_i(resp_rdata),
      .mem_resp_err_i(resp_err),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_rdata_o(out_rdata), .out_rd_o(out_rd),
      .out_we_o(out_we), .out_err_o(out_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int unsigned nbytes(input logic [1:0] sz);
      return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
   endfunction

   function automatic logic [3:0] ref_strb(input logic [1:0] sz, input int unsigned off);
      logic [3:0] s;
      for (int unsigned i = 0; i < 4; i++)
         s[i] = (i >= off) && (i < off + nbytes(sz));
      return s;
   endfunction

   function automatic logic [31:0] ref_lanes(input logic [1:0] sz, input logic [31:0] wd);
      logic [31:0] r;
      for (int unsigned i = 0; i < 4; i++)
         r[8*i +: 8] = wd[8*(i % nbytes(sz)) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sg,
                                            input int unsigned off, input logic [31:0] rdw);
      longint unsigned r, span, v;
      r    = rdw;
      span = 64'd1 << (8 * nbytes(sz));
      v    = (r >> (8 * off)) % span;
      if (sg && (v >= span / 2)) v = v - span;
      return v[31:0];
   endfunction

   task automatic idle_inputs();
      in_valid   = 1'b0;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      resp_rdata = $urandom;
      out_ready  = 1'b0;
   endtask

   // One complete transaction with bounded, deterministic stall lengths.
   task automatic run_op(input logic w, input logic r, input logic sg, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] d,
                         input int req_dly, input int out_dly,
                         input logic [31:0] mem_word, input logic berr);
      int unsigned off;
      bit          bad, nop, go;
      logic        e_err, e_we;
      logic [31:0] e_rdata;
      int          t0;
      off = a % 4;
      bad = ((sz == 2'd1) && (a % 2 != 0)) || ((sz == 2'd2) && (a % 4 != 0)) ||
            (sz == 2'd3) || (w && r);
      nop = !w && !r;
      go  = !bad && !nop;
      e_err   = bad || (go && berr);
      e_we    = go && r && !berr;
      e_rdata = e_we ? ref_load(sz, sg, off, mem_word) : 32'd0;

      @(negedge clk);
      chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1; wen = w; ren = r; sgn = sg; size = sz; addr = a; wdata = wd; rd = d;
      t0 = cyc;
      @(negedge clk);
      in_valid = 1'b0;
      wen = $urandom; ren = $urandom; sgn = $urandom; size = $urandom;
      addr = $urandom; wdata = $urandom; rd = $urandom;
      chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
      if (go) begin
         for (int k = 0; k <= req_dly; k++) begin
            if (k > 0) begin
               @(negedge clk);
               chk("in_ready_req", {31'd0, in_ready}, 32'd0);
            end
            chk("req_valid", {31'd0, req_valid}, 32'd1);
            chk("req_we", {31'd0, req_we}, {31'd0, w});
            chk("req_addr", req_addr, (a / 4) * 4);
            chk("req_wstrb", {28'd0, req_wstrb}, w ? {28'd0, ref_strb(sz, off)} : 32'd0);
            if (w) chk("req_wdata", req_wdata, ref_lanes(sz, wd));
            req_ready  = (k == req_dly);
            resp_valid = (k != req_dly) && ($urandom_range(0, 1) == 1);
            resp_err   = $urandom;
         end
         @(negedge clk);
         req_ready  = 1'b0;
         chk("req_dropped", {31'd0, req_valid}, 32'd0);
         chk("wait_no_out", {31'd0, out_valid}, 32'd0);
         resp_valid = 1'b1; resp_rdata = mem_word; resp_err = berr;
         @(negedge clk);
         resp_valid = 1'b0; resp_rdata = $urandom; resp_err = $urandom;
      end else begin
         chk("no_req", {31'd0, req_valid}, 32'd0);
      end
      chk("latency", cyc - t0, go ? 3 + req_dly : 1);
      for (int k = 0; k <= out_dly; k++) begin
         if (k > 0) begin
            resp_valid = $urandom;
            @(negedge clk);
            resp_valid = 1'b0;
         end
         chk("out_valid", {31'd0, out_valid}, 32'd1);
         chk("out_err", {31'd0, out_err}, {31'd0, e_err});
         chk("out_we", {31'd0, out_we}, {31'd0, e_we});
         chk("out_rdata", out_rdata, e_rdata);
         chk("out_rd", {27'd0, out_rd}, {27'd0, d});
         chk("in_ready_done", {31'd0, in_ready}, 32'd0);
         chk("done_no_req", {31'd0, req_valid}, 32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("out_released", {31'd0, out_valid}, 32'd0);
      chk("in_ready_back", {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      idle_inputs();
      wen = 0; ren = 0; sgn = 0; size = 0; addr = 0; wdata = 0; rd = 0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_req_valid", {31'd0, req_valid}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_err", {31'd0, out_err}, 32'd0);
      chk("rst_out_we", {31'd0, out_we}, 32'd0);
      chk("rst_out_rdata", out_rdata, 32'd0);
      chk("rst_out_rd", {27'd0, out_rd}, 32'd0);
      chk("rst_req_fields", req_addr | req_wdata | {28'd0, req_wstrb} | {31'd0, req_we}, 32'd0);
      rst = 1'b0;

      run_op(0, 1, 1, 2'd0, 32'h8000_0003, 32'h0, 5'd7, 0, 0, 32'h80FF_1234, 0);
      run_op(1, 0, 0, 2'd1, 32'h8000_0002, 32'hDEAD_BEEF, 5'd3, 0, 0, 32'h0, 0);
      run_op(0, 1, 0, 2'd2, 32'h8000_0001, 32'h0, 5'd9, 0, 0, 32'h0, 0);
      run_op(0, 1, 0, 2'd1, 32'h0000_0042, 32'h0, 5'd12, 5, 4, 32'hCAFE_F00D, 0);
      run_op(0, 1, 0, 2'd2, 32'h0000_0100, 32'h0, 5'd31, 0, 0, 32'h1234_5678, 1);
      run_op(0, 0, 0, 2'd2, 32'h0000_0010, 32'h0, 5'd4, 0, 1, 32'h0, 0);
      run_op(1, 1, 0, 2'd0, 32'h0000_0010, 32'h55, 5'd5, 0, 0, 32'h0, 0);
      run_op(0, 1, 0, 2'd3, 32'h0000_0010, 32'h0, 5'd6, 0, 0, 32'h0, 0);

      // Reset while waiting for a response; the late response must be dropped.
      @(negedge clk);
      in_valid = 1'b1; wen = 0; ren = 1; sgn = 0; size = 2'd2; addr = 32'h200; rd = 5'd8;
      @(negedge clk);
      in_valid = 1'b0; req_ready = 1'b1;
      @(negedge clk);
      req_ready = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rstw_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rstw_out_valid", {31'd0, out_valid}, 32'd0);
      resp_valid = 1'b1; resp_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      resp_valid = 1'b0;
      repeat (2) begin
         chk("rstw_late_out", {31'd0, out_valid}, 32'd0);
         chk("rstw_late_ready", {31'd0, in_ready}, 32'd1);
         chk("rstw_late_req", {31'd0, req_valid}, 32'd0);
         @(negedge clk);
      end

      for (int n = 0; n < 300; n++) begin
         logic [1:0] kind;
         kind = $urandom_range(0, 3);
         run_op(kind == 2'd1 || kind == 2'd3, kind == 2'd0 || kind == 2'd3 || kind == 2'd2,
                $urandom, $urandom, $urandom, $urandom, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 2),
                $urandom, ($urandom_range(0, 7) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
